exp_iter: RTL and testbench

//  Sequential, parametrised evaluator of y = exp(x*beta) used by the replica

---
 rtl/exp_iter_if.sv | 25 ++
 rtl/exp_iter.sv | 111 +++++++++++
 tb/tb_exp_iter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exp_iter_if.sv
// exp_iter_if: request/result handshake bundle for exp_iter; in_rnd/out_accept exist only with EXP_METRO_EN
interface exp_iter_if #(parameter int BETA_W = 12, parameter int TAG_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [20:0]       in_x;
    logic [BETA_W-1:0] in_beta;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [26:0]       out_y;
    logic [TAG_W-1:0]  out_tag;
`ifdef EXP_METRO_EN
    logic [22:0]       in_rnd;
    logic              out_accept;
    modport master (output in_valid, in_x, in_beta, in_tag, in_rnd, out_ready,
                    input in_ready, out_valid, out_y, out_tag, out_accept);
    modport slave (input in_valid, in_x, in_beta, in_tag, in_rnd, out_ready,
                   output in_ready, out_valid, out_y, out_tag, out_accept);
`else
    modport master (output in_valid, in_x, in_beta, in_tag, out_ready,
                    input in_ready, out_valid, out_y, out_tag);
    modport slave (input in_valid, in_x, in_beta, in_tag, out_ready,
                   output in_ready, out_valid, out_y, out_tag);
`endif
endinterface

// File: rtl/exp_iter.sv
// exp_iter: sequential y = exp(x*beta) via Horner Taylor series, one term per clock
// EXP_METRO_EN adds the captured in_rnd and the out_accept = out_y > rnd comparator
module exp_iter #(
    parameter int NTERM  = 15,
    parameter int BETA_W = 12,
    parameter int TAG_W  = 8
) (
    input logic       clk,
    input logic       reset_n,
    exp_iter_if.slave io
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;
    state_t             state;
    logic signed [20:0] x, xs;
    logic [BETA_W-1:0]  beta;
    logic signed [31:0] xx;
    logic signed [42:0] prod;
    logic signed [26:0] y, ynew, yfin;
    logic signed [17:0] z;
    logic [4:0]         i;
    logic               neg, clamp, fin;
    logic signed [16:0] recip [32];

    assign recip[0] = '0;
    for (genvar k = 1; k < 32; k++) begin : g_recip
        assign recip[k] = 17'(32768 / k);
    end

    function automatic logic signed [17:0] zterm(input logic signed [20:0] a, input logic signed [16:0] r);
        return 18'((38'(a) * 38'(r)) >>> 18);
    endfunction

    always_comb begin
        xx    = 32'(x) * 32'($signed({1'b0, beta}));
        clamp = xx < -(32'sd8 <<< 17) || xx >= 0;
        prod  = 43'(z) * 43'($signed(y[24:0]));
        ynew  = 27'((prod + (43'sd1 <<< 37)) >>> 14);
        yfin  = state == PREP ? (xx >= 0 ? 27'sd1 <<< 23 : '0) : (neg | ynew[26] ? '0 : ynew);
        fin   = (state == PREP && clamp) || (state == ITER && i == 5'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            io.in_ready  <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_y     <= '0;
            io.out_tag   <= '0;
            x            <= '0;
            xs           <= '0;
            beta         <= '0;
            y            <= '0;
            z            <= '0;
            i            <= '0;
            neg          <= 1'b0;
        end else begin
            if (fin) begin
                io.out_y     <= yfin;
                io.out_valid <= 1'b1;
                state        <= DONE;
            end
            case (state)
                IDLE: begin
                    io.in_ready <= 1'b1;
                    if (io.in_valid && io.in_ready) begin
                        x           <= io.in_x;
                        beta        <= io.in_beta;
                        io.out_tag  <= io.in_tag;
                        io.in_ready <= 1'b0;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    xs  <= xx[20:0];
                    y   <= 27'sd1 <<< 23;
                    z   <= zterm(xx[20:0], recip[NTERM]);
                    i   <= 5'(NTERM);
                    neg <= 1'b0;
                    if (!clamp) state <= ITER;
                end
                ITER: begin
                    y   <= ynew;
                    z   <= zterm(xs, recip[i - 5'd1]);
                    i   <= i - 5'd1;
                    neg <= neg | ynew[26];
                end
                DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef EXP_METRO_EN
    logic [22:0] rnd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd           <= '0;
            io.out_accept <= 1'b0;
        end else begin
            if (state == IDLE && io.in_valid && io.in_ready) rnd <= io.in_rnd;
            if (fin) io.out_accept <= yfin > $signed({4'b0, rnd});
        end
    end
`endif
endmodule

// File: tb/tb_exp_iter.sv
// tb_exp_iter: randomized and directed checks of exp_iter against a plain-arithmetic Taylor model
module tb_exp_iter;
    localparam int NTERM  = 15;
    localparam int BETA_W = 12;
    localparam int TAG_W  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_iter_if #(.BETA_W(BETA_W), .TAG_W(TAG_W)) bus ();
    exp_iter #(.NTERM(NTERM), .BETA_W(BETA_W), .TAG_W(TAG_W)) dut (.clk(clk), .reset_n(reset_n), .io(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint prod_xx(input logic [20:0] x, input logic [11:0] b);
        return sx(sx(longint'(x), 21) * longint'(b), 32);
    endfunction

    // Horner series from the highest term down: y = 1 + (xx/k) * y
    function automatic longint exp_model(input longint xx);
        longint y, z;
        bit neg;
        if (xx < -(8 << 17)) return 0;
        if (xx >= 0) return 1 << 23;
        y = 1 << 23;
        neg = 0;
        for (int k = NTERM; k >= 1; k--) begin
            z = sx((xx * (32768 / k)) >>> 18, 18);
            y = sx(((longint'(1) << 37) + z * sx(y, 25)) >>> 14, 27);
            neg = neg | (y < 0);
        end
        return neg ? 0 : y;
    endfunction

    task automatic run(input logic [20:0] x, input logic [11:0] b, input logic [7:0] t,
                       input logic [22:0] r, input int hold, output longint yo);
        longint xx, ey;
        int n, lat;
        xx = prod_xx(x, b);
        ey = exp_model(xx);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_beta  = b;
        bus.in_tag   = t;
`ifdef EXP_METRO_EN
        bus.in_rnd   = r;
`endif
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", bus.in_ready, 1);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            bus.in_x    = 21'($urandom);
            bus.in_beta = 12'($urandom);
            bus.in_tag  = 8'($urandom);
        end
        bus.in_valid = 1'b0;
        check("latency", lat, (xx < -(8 << 17) || xx >= 0) ? 2 : NTERM + 2);
        check("y", $signed(bus.out_y), ey);
        check("tag", bus.out_tag, t);
        check("busy_rdy", bus.in_ready, 0);
`ifdef EXP_METRO_EN
        check("accept", bus.out_accept, ey > longint'(r));
`endif
        yo = $signed(bus.out_y);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_y", $signed(bus.out_y), ey);
            check("hold_tag", bus.out_tag, t);
            check("hold_rdy", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drop_valid", bus.out_valid, 0);
        check("idle_rdy", bus.in_ready, 1);
    endtask

    initial begin
        longint yo;
        logic [20:0] rx;
        logic [11:0] rb;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_beta   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
`ifdef EXP_METRO_EN
        bus.in_rnd    = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_rdy", bus.in_ready, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_y", bus.out_y, 0);
        check("rst_tag", bus.out_tag, 0);
`ifdef EXP_METRO_EN
        check("rst_accept", bus.out_accept, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", bus.in_ready, 1);

        run(21'd0, 12'd5, 8'h11, 23'h0, 0, yo);
        check("one", yo, 1 << 23);
        run(21'h1E0000, 12'd1, 8'h22, 23'h200000, 0, yo);
        check("e1_band", yo >= 3085996 - 128 && yo <= 3085996 + 128, 1);
        run(21'h1F0000, 12'd20, 8'h33, 23'h0, 0, yo);
        check("clamp0", yo, 0);
        run(21'h1E0000, 12'd1, 8'h44, 23'h700000, 10, yo);

        bus.in_valid = 1'b1;
        bus.in_x     = 21'h1E0000;
        bus.in_beta  = 12'd1;
        bus.in_tag   = 8'h55;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_valid", bus.out_valid, 0);
        check("abort_rdy", bus.in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerel_rdy", bus.in_ready, 1);
        check("rerel_valid", bus.out_valid, 0);
        run(21'd0, 12'd3, 8'h66, 23'h0, 0, yo);
        check("post_abort", yo, 1 << 23);

        for (int n = 0; n < 40; n++) begin
            rx = 21'($urandom);
            rb = (n % 3 == 0) ? 12'($urandom) : 12'($urandom_range(1, 8));
            if (n % 4 != 3) rx[20] = 1'b1;
            run(rx, rb, 8'($urandom), 23'($urandom), $urandom_range(0, 2), yo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
